zero_window_arbiter: RTL and testbench

//   Shares one serial zero-count engine among NREQ requesters. Each requester

---
 rtl/zero_window_arbiter.sv | 141 ++++++++++++++
 tb/tb_zero_window_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/zero_window_arbiter.sv
// Round-robin arbiter feeding one serial zero-count engine.
// A granted window is scanned one sample per clock, then reported.
module zero_window_arbiter #(
    parameter  int NREQ   = 4,
    parameter  int WIN    = 3,
    parameter  int THRESH = 2,
    localparam int CW     = $clog2(WIN + 1),
    localparam int IDW    = $clog2(NREQ),
    localparam int IW     = $clog2(WIN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIN-1:0]   win_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [CW-1:0]         res_count,
    output logic                  res_detect,
    output logic [15:0]           det_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIN-1:0]  shadow_q, shadow_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rv_q, rv_d;
    logic [IDW-1:0]  rid_q, rid_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic            rdet_q, rdet_d;
    logic [15:0]     det_q, det_d;

    logic            found;
    logic [IDW-1:0]  pick;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        gnt_d    = '0;
        rv_d     = 1'b0;
        rid_d    = rid_q;
        rcnt_d   = rcnt_q;
        rdet_d   = rdet_q;
        det_d    = det_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d    = NREQ'(1) << pick;
                    shadow_d = win_data[int'(pick)*WIN +: WIN];
                    owner_d  = pick;
                    rr_d     = (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (!shadow_q[idx_q]) cnt_d = cnt_q + CW'(1);
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(WIN - 1)) state_d = REPORT;
            end
            REPORT: begin
                rv_d   = 1'b1;
                rid_d  = owner_q;
                rcnt_d = cnt_q;
                rdet_d = (cnt_q >= CW'(THRESH));
                if (rdet_d && det_q != 16'hFFFF) det_d = det_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            rv_q     <= 1'b0;
            rid_q    <= '0;
            rcnt_q   <= '0;
            rdet_q   <= 1'b0;
            det_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            rv_q     <= rv_d;
            rid_q    <= rid_d;
            rcnt_q   <= rcnt_d;
            rdet_q   <= rdet_d;
            det_q    <= det_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = (state_q != IDLE);
    assign res_valid  = rv_q;
    assign res_id     = rid_q;
    assign res_count  = rcnt_q;
    assign res_detect = rdet_q;
    assign det_cnt    = det_q;

endmodule

// File: tb/tb_zero_window_arbiter.sv
// Bench for zero_window_arbiter: per-cycle compare against a
// countdown/popcount model, plus directed literal expectations.
module tb_zero_window_arbiter;

    localparam int NREQ   = 4;
    localparam int WIN    = 3;
    localparam int THRESH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] win_data;
    logic [3:0]  gnt;
    logic        busy;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [1:0]  res_count;
    logic        res_detect;
    logic [15:0] det_cnt;

    zero_window_arbiter #(.NREQ(NREQ), .WIN(WIN), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .req(req), .win_data(win_data),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
        .res_count(res_count), .res_detect(res_detect), .det_cnt(det_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: cycles left until the engine is free, and the result
    // (popcount of zeros) computed up front at grant time.
    int         m_left, m_rr, m_pid, m_pcnt;
    int         m_id, m_cnt, m_detcnt;
    logic [3:0] m_gnt;
    logic       m_rv, m_det;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_rr = 0; m_pid = 0; m_pcnt = 0;
        m_id = 0; m_cnt = 0; m_detcnt = 0;
        m_gnt = '0; m_rv = 1'b0; m_det = 1'b0;
    endtask

    task automatic model_step();
        logic [WIN-1:0] w;
        int j;
        if (rst) return;
        m_gnt = '0;
        m_rv  = 1'b0;
        if (m_left == 0) begin
            if (req != 0) begin
                j = -1;
                for (int k = 0; k < NREQ; k++)
                    if (j < 0 && req[(m_rr + k) % NREQ]) j = (m_rr + k) % NREQ;
                m_gnt  = 4'(1 << j);
                w      = WIN'(win_data >> (j * WIN));
                m_pcnt = WIN - $countones(w);
                m_pid  = j;
                m_rr   = (j + 1) % NREQ;
                m_left = WIN + 1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_rv  = 1'b1;
                m_id  = m_pid;
                m_cnt = m_pcnt;
                m_det = (m_cnt >= THRESH);
                if (m_det && m_detcnt < 65535) m_detcnt++;
            end
        end
    endtask

    task automatic compare();
        chk("gnt", gnt, m_gnt);
        chk("busy", busy, m_left != 0);
        chk("res_valid", res_valid, m_rv);
        chk("res_id", res_id, m_id);
        chk("res_count", res_count, m_cnt);
        chk("res_detect", res_detect, m_det);
        chk("det_cnt", det_cnt, m_detcnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rv", res_valid, 1'b0);
        chk("rst_det", det_cnt, 16'd0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input logic [3:0] exp, input int bound,
                            output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            tick();
            if (gnt != 0) begin
                at = cyc;
                break;
            end
        end
        chk("gnt_lit", gnt, exp);
    endtask

    task automatic run_window(input logic [2:0] w0, input logic [1:0] ecnt,
                              input logic edet, input logic [15:0] edc);
        int at;
        win_data = {9'd0, w0};
        req = 4'b0001;
        wait_gnt(4'b0001, 10, at);
        req = 4'b0000;
        repeat (4) tick();
        chk("lit_rv", res_valid, 1'b1);
        chk("lit_id", res_id, 2'd0);
        chk("lit_cnt", res_count, ecnt);
        chk("lit_det", res_detect, edet);
        chk("lit_dc", det_cnt, edc);
        tick();
    endtask

    initial begin
        int at, prev;
        logic [3:0] exp_seq [5];
        rst = 1'b1;
        req = '0;
        win_data = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        run_window(3'b010, 2'd2, 1'b1, 16'd1);
        run_window(3'b111, 2'd0, 1'b0, 16'd1);
        run_window(3'b110, 2'd1, 1'b0, 16'd1);

        do_reset();
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        win_data = '0;
        req = 4'b1111;
        prev = -1;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(exp_seq[g], 10, at);
            if (g > 0) chk("gap", at - prev, 5);
            prev = at;
        end
        req = 4'b0000;
        repeat (8) tick();

        req = 4'b0010;
        wait_gnt(4'b0010, 10, at);
        req = 4'b0000;
        repeat (6) tick();
        req = 4'b0011;
        wait_gnt(4'b0001, 10, at);
        wait_gnt(4'b0010, 10, at);
        req = 4'b0000;
        repeat (6) tick();

        win_data = 12'b000_000_000_011;
        req = 4'b0001;
        wait_gnt(4'b0001, 10, at);
        req = 4'b1010;
        win_data = 12'hFFF;
        tick();
        win_data = 12'h000;
        req = 4'b0000;
        repeat (3) tick();
        chk("scan_rv", res_valid, 1'b1);
        chk("scan_cnt", res_count, 2'd1);
        tick();

        win_data = '0;
        req = 4'b0001;
        wait_gnt(4'b0001, 10, at);
        req = 4'b0000;
        tick();
        do_reset();
        chk("post_rst_cnt", res_count, 2'd0);
        repeat (6) tick();
        req = 4'b0100;
        wait_gnt(4'b0100, 10, at);
        req = 4'b0000;
        repeat (6) tick();

        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom);
            win_data = 12'($urandom);
            tick();
        end
        req = '0;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
